// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state type, pattern constant and default sizes for the memory sequence initiator
// Compile option MEM_SEQ_TIMEOUT_EN adds the ABORT state.
package mem_seq_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 256;
    localparam int ADDRE_DEF = 8;
    localparam logic [31:0] GOLDEN = 32'h9E37_79B1;
`ifdef MEM_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, WR, RD, DONE, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
`endif
endpackage

// File: rtl/mem_seq_pattern.sv
// mem_seq_pattern: address-derived test word, data = seed ^ (addr * GOLDEN) mod 2^WIDTH
// Ports: addr (word address), seed (run seed) -> data (pattern word).
module mem_seq_pattern
    import mem_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ADDRE = ADDRE_DEF
) (
    input  logic [ADDRE-1:0] addr,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] data
);
    localparam logic [WIDTH-1:0] G = WIDTH'(GOLDEN);
    assign data = seed ^ (WIDTH'(addr) * G);
endmodule

// File: rtl/mem_seq_initiator.sv
// mem_seq_initiator: writes an address-derived pattern over a memory window, reads it back and counts mismatches
// Ports: clk_i/rst_i (async active-high); control start_i, dir_i, seed_i, start_addr_i, num_loc_i;
// status busy_o, done_o, pass_o, err_count_o, first_err_addr_o, abort_o;
// memory request valid_o, wrdata_o, addre_o, write_o; response read_i, ready_i.
// Define MEM_SEQ_TIMEOUT_EN to abort a run when ready_i stays low for TIMEOUT cycles.
module mem_seq_initiator
    import mem_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDRE   = ADDRE_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [ADDRE-1:0] start_addr_i,
    input  logic [ADDRE:0]   num_loc_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ADDRE:0]   err_count_o,
    output logic [ADDRE-1:0] first_err_addr_o,
    output logic             abort_o,
    output logic             valid_o,
    output logic             wrdata_o,
    output logic [ADDRE-1:0] addre_o,
    output logic [WIDTH-1:0] write_o,
    input  logic [WIDTH-1:0] read_i,
    input  logic             ready_i
);
    localparam logic [ADDRE:0] NMAX = (ADDRE+1)'(DEPTH);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end
    state_t           state, state_n;
    logic [ADDRE-1:0] addr, base;
    logic [ADDRE:0]   num, cnt, num_c;
    logic             dir, pass_r, last, to_hit;
    logic [WIDTH-1:0] seed, pat;
    mem_seq_pattern #(.WIDTH(WIDTH), .ADDRE(ADDRE)) u_pat (.addr(addr), .seed(seed), .data(pat));
    assign num_c = (num_loc_i > NMAX) ? NMAX : num_loc_i;
    assign last  = (cnt + 1'b1) == num;
`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          abort_r;
    assign to_hit  = valid_o && !ready_i && tcnt == TW'(TIMEOUT - 1);
    assign abort_o = abort_r;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) tcnt <= '0;
        else       tcnt <= (valid_o && !ready_i) ? tcnt + 1'b1 : '0;
`else
    assign to_hit  = 1'b0;
    assign abort_o = 1'b0;
`endif
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start_i ? ((num_c == '0) ? DONE : WR) : IDLE;
            WR:      state_n = (ready_i && last) ? RD : WR;
            RD:      state_n = (ready_i && last) ? DONE : RD;
            default: state_n = IDLE;
        endcase
`ifdef MEM_SEQ_TIMEOUT_EN
        if (to_hit) state_n = ABORT;
`endif
    end
    assign valid_o  = state == WR || state == RD;
    assign wrdata_o = state == WR;
    assign write_o  = (state == WR) ? pat : '0;
    assign addre_o  = addr;
    assign busy_o   = state != IDLE;
    assign done_o   = !(state == IDLE || valid_o);
    // pass shows alongside the DONE pulse, then the register holds it until the next start
    assign pass_o   = pass_r || (state == DONE && err_count_o == '0);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr <= '0; base <= '0; num <= '0; cnt <= '0; dir <= 1'b0; seed <= '0;
            err_count_o <= '0; first_err_addr_o <= '0; pass_r <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
            abort_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    addr <= start_addr_i; base <= start_addr_i; num <= num_c; cnt <= '0;
                    dir <= dir_i; seed <= seed_i;
                    err_count_o <= '0; first_err_addr_o <= '0; pass_r <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
                    abort_r <= 1'b0;
`endif
                end
                WR: if (ready_i) begin
                    cnt  <= last ? '0 : cnt + 1'b1;
                    addr <= !last ? addr + 1'b1 : dir ? base + ADDRE'(num - 1'b1) : base;
                end
                RD: if (ready_i) begin
                    cnt  <= cnt + 1'b1;
                    addr <= dir ? addr - 1'b1 : addr + 1'b1;
                    if (read_i != pat) begin
                        err_count_o <= err_count_o + 1'b1;
                        if (err_count_o == '0) first_err_addr_o <= addr;
                    end
                end
                DONE: pass_r <= err_count_o == '0;
                default: ;
            endcase
`ifdef MEM_SEQ_TIMEOUT_EN
            if (to_hit) abort_r <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mem_seq_initiator.sv
// tb_mem_seq_initiator: randomized memory responder with a transaction-queue model of the expected run
module tb_mem_seq_initiator;
    localparam int TO = 1024;
    logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, dir_i = 1'b0, ready_i = 1'b0;
    logic [31:0] seed_i = '0, read_i = '0;
    logic [7:0]  start_addr_i = '0;
    logic [8:0]  num_loc_i = '0;
    logic        busy_o, done_o, pass_o, abort_o, valid_o, wrdata_o;
    logic [8:0]  err_count_o;
    logic [7:0]  first_err_addr_o, addre_o;
    logic [31:0] write_o;
    typedef struct {logic wr; logic [7:0] a; logic [31:0] d;} exp_t;
    logic [31:0] mem [256];
    bit          fault [256];
    int          n_chk = 0, n_fail = 0, last_cyc = 0;

    mem_seq_initiator #(.WIDTH(32), .DEPTH(256), .ADDRE(8), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i), .seed_i(seed_i),
        .start_addr_i(start_addr_i), .num_loc_i(num_loc_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .abort_o(abort_o), .valid_o(valid_o), .wrdata_o(wrdata_o), .addre_o(addre_o),
        .write_o(write_o), .read_i(read_i), .ready_i(ready_i));

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] pat(input logic [31:0] sd, input logic [7:0] a);
        return sd ^ ({24'b0, a} * 32'h9E37_79B1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One run: the model is the ordered list of requests the window must produce.
    task automatic run(input logic [31:0] sd, input logic [7:0] sa, input int n, input logic d, input int smax);
        int nc = (n > 256) ? 256 : n;
        int ee = 0, fe = -1, cyc, stall;
        logic [7:0] a;
        exp_t q[$];
        for (int i = 0; i < nc; i++) q.push_back('{1'b1, 8'(sa + i), pat(sd, 8'(sa + i))});
        for (int i = 0; i < nc; i++) begin
            a = d ? 8'(sa + nc - 1 - i) : 8'(sa + i);
            q.push_back('{1'b0, a, 32'b0});
            if (fault[a]) begin ee++; if (fe < 0) fe = a; end
        end
        start_i = 1'b1; dir_i = d; seed_i = sd; start_addr_i = sa; num_loc_i = 9'(n);
        @(posedge clk_i); @(negedge clk_i);
        start_i = 1'b0; dir_i = ~d; seed_i = $urandom; start_addr_i = 8'($urandom); num_loc_i = 9'($urandom);
        cyc = 1; stall = $urandom_range(0, smax);
        while (!done_o && cyc < 4000) begin
            chk("busy", busy_o, 1);
            if (q.size() > 0) begin
                chk("valid", valid_o, 1);
                chk("wrdata", wrdata_o, q[0].wr);
                chk("addr", addre_o, q[0].a);
                chk("wdata", write_o, q[0].d);
            end else chk("valid_idle", valid_o, 0);
            ready_i = 1'b0;
            if (q.size() > 0 && stall == 0) begin
                ready_i = 1'b1;
                if (q[0].wr) mem[addre_o] = write_o;
                else read_i = mem[addre_o] ^ {31'b0, fault[addre_o]};
            end else if (stall > 0) stall--;
            start_i = ($urandom_range(0, 3) == 0);
            @(posedge clk_i);
            if (ready_i) begin void'(q.pop_front()); stall = $urandom_range(0, smax); end
            @(negedge clk_i);
            cyc++;
        end
        ready_i = 1'b0; start_i = 1'b0; last_cyc = cyc;
        chk("done_seen", done_o, 1);
        chk("queue_left", q.size(), 0);
        if (smax == 0) chk("run_cycles", cyc, 2 * nc + 1);
        chk("err_count", err_count_o, ee);
        if (ee > 0) chk("first_err", first_err_addr_o, fe);
        chk("pass", pass_o, ee == 0);
        chk("abort", abort_o, 0);
        @(posedge clk_i); @(negedge clk_i);
        chk("done_pulse", done_o, 0);
        chk("busy_after", busy_o, 0);
        chk("pass_held", pass_o, ee == 0);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        foreach (fault[i]) fault[i] = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", valid_o, 0); chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0); chk("rst_addr", addre_o, 0); chk("rst_wdata", write_o, 0);
        chk("rst_err", err_count_o, 0); chk("rst_abort", abort_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("pin_pat1", pat(32'h0, 8'h01), 32'h9E37_79B1);
        chk("pin_pat2", pat(32'h0, 8'h02), 32'h3C6E_F362);
        chk("pin_patff", pat(32'h0, 8'hFF), 32'h9942_374F);
        chk("pin_seed", pat(32'hA5A5_A5A5, 8'h01), 32'h3B92_DC14);
        run(32'h0, 8'h00, 256, 1'b0, 0);
        chk("full_cycles", last_cyc, 513);
        run(32'hA5A5_A5A5, 8'h10, 16, 1'b1, 0);
        run(32'h1357_9BDF, 8'hFE, 4, 1'b0, 3);
        run(32'h2468_ACE0, 8'hFE, 4, 1'b1, 3);
        fault[5] = 1; fault[9] = 1;
        run(32'hDEAD_BEEF, 8'h00, 16, 1'b0, 1);
        chk("fault_cnt", err_count_o, 2);
        chk("fault_first", first_err_addr_o, 8'h05);
        chk("fault_pass", pass_o, 0);
        fault[5] = 0; fault[9] = 0;
        run(32'h1111_2222, 8'h40, 0, 1'b0, 0);
        chk("zero_cycles", last_cyc, 1);
        run(32'h3333_4444, 8'h80, 300, 1'b1, 0);
        chk("clamp_cycles", last_cyc, 513);
        for (int r = 0; r < 6; r++) begin
            fault[$urandom_range(0, 255)] = 1;
            fault[$urandom_range(0, 255)] = 1;
            run($urandom, 8'($urandom), $urandom_range(0, 300), 1'($urandom), $urandom_range(0, 2));
            foreach (fault[i]) fault[i] = 0;
        end
        // asynchronous reset in the middle of the read-back phase
        start_i = 1'b1; dir_i = 1'b0; seed_i = 32'h1234_5678; start_addr_i = 8'h30; num_loc_i = 9'd16;
        ready_i = 1'b1; read_i = '0;
        @(posedge clk_i); @(negedge clk_i);
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        chk("mid_rd_valid", valid_o, 1);
        chk("mid_rd_phase", wrdata_o, 0);
        chk("mid_rd_errs", err_count_o != 0, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", valid_o, 0); chk("arst_busy", busy_o, 0); chk("arst_done", done_o, 0);
        chk("arst_addr", addre_o, 0); chk("arst_err", err_count_o, 0); chk("arst_first", first_err_addr_o, 0);
        chk("arst_pass", pass_o, 0); chk("arst_wrdata", wrdata_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0; ready_i = 1'b0;
        @(negedge clk_i);
        chk("arst_idle", busy_o, 0);
        run(32'h0BAD_F00D, 8'hF8, 12, 1'b1, 2);
`ifdef MEM_SEQ_TIMEOUT_EN
        begin
            int cyc = 1;
            start_i = 1'b1; dir_i = 1'b0; seed_i = '0; start_addr_i = 8'h00; num_loc_i = 9'd4; ready_i = 1'b0;
            @(posedge clk_i); @(negedge clk_i);
            start_i = 1'b0;
            while (!done_o && cyc < TO + 100) begin @(negedge clk_i); cyc++; end
            chk("to_done", done_o, 1);
            chk("to_cycles", cyc, TO + 1);
            chk("to_abort", abort_o, 1);
            chk("to_pass", pass_o, 0);
            chk("to_valid", valid_o, 0);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_seq_initiator.md
# mem_seq_initiator

Hardware initiator for the single-port memory valid/ready interface. It exercises the memory's responder side. After a `start_i` pulse it writes a deterministic address-derived pattern over a contiguous address window in ascending order. It then reads the same window back, in ascending or descending order, and compares each word against the regenerated pattern. It reports a pass/fail summary and sits between a test/control register block and the memory instance.

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 256, number of memory locations (= 2^ADDRE)
- `ADDRE`, 8, address width
- `TIMEOUT`, 1024, max cycles waiting for `ready_i` per transaction (used only with `MEM_SEQ_TIMEOUT_EN`)
- `clk_i` in 1, single clock, rising edge
- `rst_i` in 1, reset, asynchronous, active-high
- `start_i` in 1, start request, sampled only in IDLE
- `dir_i` in 1, read-back order: 0 ascending, 1 descending; latched at start
- `seed_i` in WIDTH, pattern seed; latched at start
- `start_addr_i` in ADDRE, first address of window; latched at start
- `num_loc_i` in ADDRE+1, window length; latched at start, values > DEPTH clamp to DEPTH
- `busy_o` out 1, run in progress
- `done_o` out 1, one-cycle pulse at end of run
- `pass_o` out 1, last run had zero mismatches and no abort; held until next start
- `err_count_o` out ADDRE+1, mismatches in last/current run
- `first_err_addr_o` out ADDRE, address of first mismatch
- `abort_o` out 1, last run aborted by timeout (tied 0 without macro)
- `valid_o` out 1, request valid
- `wrdata_o` out 1, 1 = write, 0 = read
- `addre_o` out ADDRE, request address
- `write_o` out WIDTH, write data
- `read_i` in WIDTH, read data, valid when `ready_i`=1 on a read
- `ready_i` in 1, memory completes current request

## Operation
- Pattern: `pat(a) = seed ^ ((zero-extended a * GOLDEN) mod 2^WIDTH)`, with `GOLDEN = 32'h9E37_79B1` truncated/extended to WIDTH.
- FSM states are IDLE, WR, RD, DONE, plus ABORT with the macro.
- IDLE: on `start_i`, latch controls, clear `err_count_o`/`first_err_addr_o`/`pass_o`/`abort_o`, and set `busy_o`.
  - If clamped `num_loc` = 0, go to DONE.
  - Otherwise go to WR with address = `start_addr`.
- WR: drive `valid_o`=1, `wrdata_o`=1, `addre_o`=addr, `write_o`=pat(addr).
  - On an edge with `ready_i`=1, the write completes and addr increments.
  - After `num_loc` completions, go to RD. Address = `start_addr` when ascending, `start_addr+num_loc-1` when descending.
- RD: drive `valid_o`=1, `wrdata_o`=0, `write_o`=0.
  - On an edge with `ready_i`=1, compare `read_i` against pat(addr).
  - On mismatch, increment `err_count_o`; on the first mismatch, also record `first_err_addr_o`.
  - Step addr ±1. After `num_loc` completions, go to DONE.
- DONE: pulse `done_o`, set `pass_o` = (`err_count` == 0), clear `busy_o`, return to IDLE.
- Address arithmetic is modulo 2^ADDRE. Windows wrap, e.g. start 0xFE with length 4 covers FE, FF, 00, 01.
- `start_i` while busy: ignored. Latched control inputs changing mid-run: no effect.
- Request fields stay stable while `valid_o`=1 and `ready_i`=0.

## Timing
- Reset values: `valid_o`, `wrdata_o`, `busy_o`, `done_o`, `pass_o`, `abort_o` = 0; `addre_o`, `write_o`, `err_count_o`, `first_err_addr_o` = 0; state IDLE.
- Reset asserted mid-run aborts immediately. No completion or flag is reported.
- `start_i` sampled at edge k puts the first WR request on the outputs at cycle k+1.
- Transfers are back-to-back: the next request appears in the cycle after a completing edge, and `valid_o` stays high.
- WR→RD transition has no idle cycle.
- Memory that holds `ready_i`=1 continuously: run takes N writes + N reads + 1 DONE cycle. `done_o` is high in cycle k+2N+1.
- A mismatch detected at edge e is visible on `err_count_o` from cycle e+1.
- The `done_o` pulse is never back-to-back with a new run. IDLE lasts ≥1 cycle.

## Configuration
- `MEM_SEQ_TIMEOUT_EN` defined:
  - A per-transaction counter clears on each completion.
  - If `TIMEOUT` cycles pass with `valid_o`=1 and no `ready_i`, enter ABORT: drop `valid_o`, set `abort_o`=1, keep `pass_o`=0, pulse `done_o`, then go to IDLE.
- `MEM_SEQ_TIMEOUT_EN` undefined: no counter, the block waits forever, and `abort_o` is tied to 0.

## Structure
- Shared package `mem_seq_pkg`: state enum, `GOLDEN` constant, default `WIDTH`/`DEPTH`/`ADDRE`.
- One combinational sub-module `mem_seq_pattern` (addr, seed → data), shared by write generation and read compare.
- FSM, counters, and scoreboard registers live in the top.

## Test plan
- Ascending, zero-wait memory, seed 0x0, start 0, N=256, dir 0 → 256 writes then 256 reads, `done_o` 513 cycles after start, `pass_o`=1, `err_count_o`=0.
- Descending read, seed 0xA5A5_A5A5, start 0x10, N=16 → reads from 0x1F down to 0x10, `pass_o`=1.
- Wrap, start 0xFE, N=4, memory ready after 3-cycle random stalls → addresses FE, FF, 00, 01 in both phases, and request fields stable during stalls.
- Fault injection: memory corrupts bit 0 at addresses 0x05 and 0x09, N=16 → `err_count_o`=2, `first_err_addr_o`=0x05, `pass_o`=0.
- N=0 → no `valid_o`, `done_o` 1 cycle after start, `pass_o`=1. N=300 → clamped to 256.
- Reset asserted during the RD phase → all outputs return to reset values asynchronously. With the macro, `ready_i` stuck 0 → `abort_o`=1 and `done_o` after `TIMEOUT` cycles.
